// File: rtl/player_action_encoder_pkg.sv
// Shared definitions for the fighter button front end: action codes, button bit
// positions, FSM state encoding and the attack pending/edge payload.
package player_action_encoder_pkg;

  localparam int unsigned ACT_W = 6;

  typedef logic [ACT_W-1:0] act_t;

  localparam act_t ACT_NONE       = 6'b000000;
  localparam act_t ACT_PUNCH      = 6'b000001;
  localparam act_t ACT_KICK       = 6'b000010;
  localparam act_t ACT_JUMP       = 6'b000100;
  localparam act_t ACT_WAIT       = 6'b001000;
  localparam act_t ACT_MOVE_LEFT  = 6'b010000;
  localparam act_t ACT_MOVE_RIGHT = 6'b100000;

  localparam int unsigned BTN_PUNCH = 0;
  localparam int unsigned BTN_KICK  = 1;
  localparam int unsigned BTN_JUMP  = 2;
  localparam int unsigned BTN_WAIT  = 3;
  localparam int unsigned BTN_LEFT  = 4;
  localparam int unsigned BTN_RIGHT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AIR  = 2'd1,
    ST_COOL = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic jump;
    logic kick;
    logic punch;
  } attack_t;

  // Level-sampled actions: right beats left beats wait, so the result stays one-hot.
  function automatic act_t level_action(input logic right, input logic left, input logic wt);
    act_t a;
    a = ACT_NONE;
    if (right)     a = ACT_MOVE_RIGHT;
    else if (left) a = ACT_MOVE_LEFT;
    else if (wt)   a = ACT_WAIT;
    return a;
  endfunction

endpackage

// File: rtl/player_action_encoder_if.sv
// Button inputs and tick-rate action outputs of one fighter's encoder.
interface player_action_encoder_if;
  import player_action_encoder_pkg::*;

  logic [ACT_W-1:0] btn_raw;
  act_t             action_out;
  logic             action_vld;
  logic             tick;

  modport master (output btn_raw, input action_out, input action_vld, input tick);
  modport slave  (input btn_raw, output action_out, output action_vld, output tick);
endinterface

// File: rtl/player_action_encoder_btn_debounce.sv
// One push-button: two-flop synchroniser followed by a consecutive-sample debouncer.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the level restarts the run; a full run flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/player_action_encoder.sv
// Fighter input front end: debounced buttons -> one prioritised one-hot action per
// game tick, with jump airtime and post-attack cooldown.
module player_action_encoder
  import player_action_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8,
  parameter int unsigned JUMP_TICKS      = 2,
  parameter int unsigned COOLDOWN_TICKS  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  player_action_encoder_if.slave act_if
);

  localparam int unsigned DIV_W  = $clog2(TICK_DIV);
  localparam int unsigned AIR_W  = $clog2(JUMP_TICKS + 1);
  localparam int unsigned COOL_W = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

  logic [ACT_W-1:0]  lvl;
  attack_t           atk_lvl_c, atk_edge_c, pend_in_c;
  attack_t           lvl_prev_q;
  attack_t           pend_q, pend_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic              vld_q, vld_d;
  act_t              act_q, act_d;
  fsm_state_t        state_q, state_d;
  logic [AIR_W-1:0]  air_q, air_d;
  logic [COOL_W-1:0] cool_q, cool_d;

  for (genvar b = 0; b < ACT_W; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (act_if.btn_raw[b]),
      .level_o(lvl[b])
    );
  end

  // Rising edges of the debounced attack buttons.
  always_comb begin
    atk_lvl_c.jump   = lvl[BTN_JUMP];
    atk_lvl_c.kick   = lvl[BTN_KICK];
    atk_lvl_c.punch  = lvl[BTN_PUNCH];
    atk_edge_c.jump  = atk_lvl_c.jump  & ~lvl_prev_q.jump;
    atk_edge_c.kick  = atk_lvl_c.kick  & ~lvl_prev_q.kick;
    atk_edge_c.punch = atk_lvl_c.punch & ~lvl_prev_q.punch;
  end

  // Tick divider plus pending latch and action FSM, all advancing on the registered tick.
  always_comb begin
    div_d   = (div_q == DIV_W'(TICK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    tick_d  = (div_d == DIV_W'(TICK_DIV - 1));
    vld_d   = tick_q;
    act_d   = act_q;
    state_d = state_q;
    air_d   = air_q;
    cool_d  = cool_q;

    // Edges arriving this cycle are visible to a tick on the same cycle.
    pend_in_c = pend_q;
    case (state_q)
      ST_IDLE: begin
        pend_in_c.jump  = pend_q.jump  | atk_edge_c.jump;
        pend_in_c.kick  = pend_q.kick  | atk_edge_c.kick;
        pend_in_c.punch = pend_q.punch | atk_edge_c.punch;
      end
      ST_COOL: pend_in_c.jump = pend_q.jump | atk_edge_c.jump;
      default: pend_in_c = '0;
    endcase
    pend_d = pend_in_c;

    if (tick_q) begin
      if (state_q == ST_AIR) begin
        act_d  = ACT_JUMP;
        pend_d = '0;
        if (air_q <= AIR_W'(1)) begin
          air_d   = '0;
          state_d = ST_IDLE;
        end else begin
          air_d = air_q - AIR_W'(1);
        end
      end else if (pend_in_c.jump) begin
        act_d   = ACT_JUMP;
        pend_d  = '0;
        cool_d  = '0;
        state_d = ST_IDLE;
        if (JUMP_TICKS > 1) begin
          state_d = ST_AIR;
          air_d   = AIR_W'(JUMP_TICKS - 1);
        end
      end else if ((state_q == ST_IDLE) && (pend_in_c.punch || pend_in_c.kick)) begin
        // Punch outranks kick; the loser stays pending for after the cooldown.
        if (pend_in_c.punch) begin
          act_d        = ACT_PUNCH;
          pend_d.punch = 1'b0;
        end else begin
          act_d       = ACT_KICK;
          pend_d.kick = 1'b0;
        end
        if (COOLDOWN_TICKS > 0) begin
          state_d = ST_COOL;
          cool_d  = COOL_W'(COOLDOWN_TICKS);
        end
      end else begin
        act_d = level_action(lvl[BTN_RIGHT], lvl[BTN_LEFT], lvl[BTN_WAIT]);
        if (state_q == ST_COOL) begin
          if (cool_q <= COOL_W'(1)) begin
            cool_d  = '0;
            state_d = ST_IDLE;
          end else begin
            cool_d = cool_q - COOL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      vld_q      <= 1'b0;
      act_q      <= ACT_NONE;
      state_q    <= ST_IDLE;
      air_q      <= '0;
      cool_q     <= '0;
      pend_q     <= '0;
      lvl_prev_q <= '0;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      vld_q      <= vld_d;
      act_q      <= act_d;
      state_q    <= state_d;
      air_q      <= air_d;
      cool_q     <= cool_d;
      pend_q     <= pend_d;
      lvl_prev_q <= atk_lvl_c;
    end
  end

  assign act_if.action_out = act_q;
  assign act_if.action_vld = vld_q;
  assign act_if.tick       = tick_q;

endmodule

// File: tb/tb_player_action_encoder.sv
// Bench for player_action_encoder: directed tick-aligned vectors and corner sequences,
// plus random button traffic, all cross-checked every cycle against a behavioural model.
module tb_player_action_encoder;

  localparam int TD = 8;
  localparam int DB = 4;
  localparam int JT = 2;
  localparam int CT = 1;

  localparam logic [5:0] B_R = 6'b100000;
  localparam logic [5:0] B_L = 6'b010000;
  localparam logic [5:0] B_W = 6'b001000;
  localparam logic [5:0] B_J = 6'b000100;
  localparam logic [5:0] B_K = 6'b000010;
  localparam logic [5:0] B_P = 6'b000001;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  player_action_encoder_if bus ();

  player_action_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD),
    .JUMP_TICKS     (JT),
    .COOLDOWN_TICKS (CT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .act_if(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_vld(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk);
      if (bus.action_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no action_vld within %0d cycles", name, 4 * TD);
    end
  endtask

  // Behavioural model: raw -> 2-cycle delay -> window of the last DB samples; the level
  // flips once the whole window disagrees with it. Game state is kept as tick budgets.
  logic [5:0]  m_s1, m_s2, m_lvl, m_prev;
  logic [5:0]  m_win [DB];
  logic        m_pj, m_pk, m_pp;
  int          m_air, m_cool;
  int unsigned m_cyc;
  logic [5:0]  m_act;
  logic        m_vld, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
      for (int i = 0; i < DB; i++) m_win[i] = '0;
      m_pj = 0; m_pk = 0; m_pp = 0;
      m_air = 0; m_cool = 0; m_cyc = 0;
      m_act = '0; m_vld = 0; m_tick = 0;
    end else begin : step
      bit tick_now, idle, fj, fk, fp, all_diff;
      tick_now = (m_cyc % TD) == TD - 1;
      idle     = (m_air == 0) && (m_cool == 0);
      fj = (m_air == 0) && (m_pj || (m_lvl[2] && !m_prev[2]));
      fk = (m_air == 0) && (m_pk || (idle && m_lvl[1] && !m_prev[1]));
      fp = (m_air == 0) && (m_pp || (idle && m_lvl[0] && !m_prev[0]));
      if (tick_now) begin
        if (m_air > 0) begin
          m_act = B_J; m_air--; m_pj = 0; m_pk = 0; m_pp = 0;
        end else if (fj) begin
          m_act = B_J; m_air = JT - 1; m_cool = 0; m_pj = 0; m_pk = 0; m_pp = 0;
        end else if (idle && fp) begin
          m_act = B_P; m_pp = 0; m_pk = fk; m_pj = 0; m_cool = CT;
        end else if (idle && fk) begin
          m_act = B_K; m_pk = 0; m_pp = 0; m_pj = 0; m_cool = CT;
        end else begin
          m_act = m_lvl[5] ? B_R : m_lvl[4] ? B_L : m_lvl[3] ? B_W : 6'b0;
          m_pj = 0; m_pp = fp; m_pk = fk;
          if (m_cool > 0) m_cool--;
        end
      end else begin
        m_pj = fj; m_pk = fk; m_pp = fp;
      end
      m_vld = tick_now;
      for (int i = DB - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_s2;
      m_prev = m_lvl;
      for (int b = 0; b < 6; b++) begin
        all_diff = 1;
        for (int i = 0; i < DB; i++) if (m_win[i][b] == m_lvl[b]) all_diff = 0;
        if (all_diff) m_lvl[b] = ~m_lvl[b];
      end
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
      m_cyc++;
      m_tick = (m_cyc % TD) == TD - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_action_out", 32'(bus.action_out), 32'(m_act));
      check("model_action_vld", 32'(bus.action_vld), 32'(m_vld));
      check("model_tick",       32'(bus.tick),       32'(m_tick));
    end
  end

  typedef struct {
    logic [5:0] btn;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    bit ok;
    int first_tick, n_ticks;

    // Each vector is pressed right after a tick's action_vld; exp is the next tick's action.
    tbl.push_back('{6'b0,        6'b0});
    tbl.push_back('{B_P,         B_P});
    tbl.push_back('{B_P,         6'b0});
    tbl.push_back('{6'b0,        6'b0});
    tbl.push_back('{B_K | B_R,   B_K});
    tbl.push_back('{B_R | B_L,   B_R});
    tbl.push_back('{B_R | B_L,   B_R});
    tbl.push_back('{B_R | B_L,   B_R});
    tbl.push_back('{B_L | B_W,   B_L});
    tbl.push_back('{B_W,         B_W});
    tbl.push_back('{B_W | B_K,   B_K});
    tbl.push_back('{B_W,         B_W});
    tbl.push_back('{B_W | B_J | B_P, B_J});
    tbl.push_back('{B_W,         B_J});
    tbl.push_back('{B_W,         B_W});
    tbl.push_back('{6'b0,        6'b0});

    bus.btn_raw = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_action_out", 32'(bus.action_out), 32'd0);
    check("reset_action_vld", 32'(bus.action_vld), 32'd0);
    check("reset_tick",       32'(bus.tick),       32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle run: ticks every TD cycles, each followed by an all-zero action.
    first_tick = -1;
    n_ticks    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.tick === 1'b1) begin
        n_ticks++;
        if (first_tick < 0) first_tick = k;
      end
      if (bus.action_vld === 1'b1) check("idle_action_zero", 32'(bus.action_out), 32'd0);
    end
    check("first_tick_cycle", 32'(first_tick), 32'(TD - 1));
    check("ticks_in_40",      32'(n_ticks),    32'd5);

    wait_vld("align", ok);
    foreach (tbl[i]) begin
      bus.btn_raw = tbl[i].btn;
      wait_vld($sformatf("vec%0d_vld", i), ok);
      check($sformatf("vec%0d_action", i), 32'(bus.action_out), 32'(tbl[i].exp));
    end

    // Two-cycle glitch on every button must not reach the debounced levels.
    bus.btn_raw = 6'h3F;
    repeat (2) @(negedge clk);
    bus.btn_raw = '0;
    wait_vld("glitch_vld", ok);
    check("glitch_action", 32'(bus.action_out), 32'd0);

    // Punch pulse, then a late re-press that lands after the cooldown tick.
    bus.btn_raw = B_P;
    repeat (6) @(negedge clk);
    bus.btn_raw = '0;
    wait_vld("punch1_vld", ok);
    check("punch1_action", 32'(bus.action_out), 32'(B_P));
    repeat (5) @(negedge clk);
    bus.btn_raw = B_P;
    wait_vld("cool_vld", ok);
    check("cool_suppressed", 32'(bus.action_out), 32'd0);
    repeat (5) @(negedge clk);
    bus.btn_raw = '0;
    wait_vld("punch2_vld", ok);
    check("punch2_action", 32'(bus.action_out), 32'(B_P));
    wait_vld("cool2_vld", ok);
    check("cool2_action", 32'(bus.action_out), 32'd0);

    // Jump and punch together: jump airtime, punch discarded.
    bus.btn_raw = B_J | B_P;
    repeat (6) @(negedge clk);
    bus.btn_raw = '0;
    wait_vld("jp1_vld", ok);
    check("jp_jump1", 32'(bus.action_out), 32'(B_J));
    wait_vld("jp2_vld", ok);
    check("jp_jump2", 32'(bus.action_out), 32'(B_J));
    wait_vld("jp3_vld", ok);
    check("jp_after", 32'(bus.action_out), 32'd0);

    // Reset in the middle of airtime.
    bus.btn_raw = B_J;
    repeat (6) @(negedge clk);
    bus.btn_raw = '0;
    wait_vld("air_vld", ok);
    check("air_jump", 32'(bus.action_out), 32'(B_J));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midair_rst_action", 32'(bus.action_out), 32'd0);
    check("midair_rst_vld",    32'(bus.action_vld), 32'd0);
    check("midair_rst_tick",   32'(bus.tick),       32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    first_tick = -1;
    for (int k = 1; k <= 4 * TD; k++) begin
      @(posedge clk);
      #1;
      if (bus.tick === 1'b1) begin
        first_tick = k;
        break;
      end
    end
    check("post_rst_first_tick", 32'(first_tick), 32'(TD - 1));
    wait_vld("post_rst_vld", ok);
    check("post_rst_action", 32'(bus.action_out), 32'd0);

    // Random traffic: mostly held levels, occasional bit flips and full re-rolls.
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 11));
      if (r == 0) bus.btn_raw = 6'($urandom);
      else if (r == 1) bus.btn_raw = bus.btn_raw ^ 6'(1 << $urandom_range(0, 5));
    end

    bus.btn_raw = '0;
    repeat (4 * TD) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
